// File: rtl/output_drain_if.sv
// Bus bundle for output_drain: drain control, BRAM port-A read side and the requantized output stream.
// The drain engine connects through the master modport; its environment uses slave.
interface output_drain_if #(
    parameter int unsigned I_WIDTH         = 8,
    parameter int unsigned F_WIDTH         = 8,
    parameter int unsigned BRAM_ADDR_WIDTH = 11,
    parameter int unsigned OUT_WIDTH       = 8,
    parameter int unsigned SHIFT_WIDTH     = $clog2(I_WIDTH + F_WIDTH)
);
    logic                             start_i;
    logic [BRAM_ADDR_WIDTH-1:0]       base_addr_i;
    logic [BRAM_ADDR_WIDTH:0]         num_words_i;
    logic [SHIFT_WIDTH-1:0]           shift_i;
    logic                             relu_en_i;
    logic [I_WIDTH+F_WIDTH-1:0]       bram_data_i;
    logic                             ready_i;
    logic [BRAM_ADDR_WIDTH-1:0]       bram_addr_o;
    logic                             bram_rd_o;
    logic [OUT_WIDTH-1:0]             data_o;
    logic                             valid_o;
    logic                             last_o;
    logic                             busy_o;
    logic                             done_o;

    modport master (
        input  start_i, base_addr_i, num_words_i, shift_i, relu_en_i, bram_data_i, ready_i,
        output bram_addr_o, bram_rd_o, data_o, valid_o, last_o, busy_o, done_o
    );

    modport slave (
        output start_i, base_addr_i, num_words_i, shift_i, relu_en_i, bram_data_i, ready_i,
        input  bram_addr_o, bram_rd_o, data_o, valid_o, last_o, busy_o, done_o
    );
endinterface

// File: rtl/output_drain.sv
// Drains N accumulated words from BRAM, requantizes each (round, shift, optional ReLU, saturate)
// and streams them out through a 2-entry FIFO under ready/valid flow control.
module output_drain #(
    parameter int unsigned I_WIDTH         = 8,
    parameter int unsigned F_WIDTH         = 8,
    parameter int unsigned BRAM_ADDR_WIDTH = 11,
    parameter int unsigned OUT_WIDTH       = 8,
    parameter int unsigned SHIFT_WIDTH     = $clog2(I_WIDTH + F_WIDTH)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    output_drain_if.master bus
);
    localparam int unsigned DW = I_WIDTH + F_WIDTH;
    localparam int unsigned EW = DW + 1;
    localparam int unsigned AW = BRAM_ADDR_WIDTH;
    localparam int unsigned CW = BRAM_ADDR_WIDTH + 1;

    localparam logic signed [EW-1:0] OMAX = EW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                 last;
        logic [OUT_WIDTH-1:0] data;
    } entry_t;

    state_e               state_q;
    logic [AW-1:0]        addr_q;
    logic [CW-1:0]        num_q;
    logic [CW-1:0]        issued_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic                 relu_q;
    logic                 pend_q;
    logic                 pend_last_q;
    entry_t               mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;

    logic                 valid_c;
    logic                 pop_c;
    logic                 push_c;
    logic                 room_c;
    logic                 rd_fire_c;
    logic                 final_rd_c;
    entry_t               head_c;
    entry_t               wr_entry_c;

    // Round half up, arithmetic shift, optional ReLU, then saturate to the signed output range.
    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic [DW-1:0]          x,
        input logic [SHIFT_WIDTH-1:0] sh,
        input logic                   relu
    );
        logic signed [EW-1:0] xe;
        logic signed [EW-1:0] rnd;
        logic signed [EW-1:0] r;
        xe  = EW'($signed(x));
        rnd = '0;
        if (sh != '0) begin
            rnd = EW'(1) << (sh - SHIFT_WIDTH'(1));
        end
        r = (xe + rnd) >>> sh;
        if (relu && r[EW-1]) begin
            r = '0;
        end
        if (r > OMAX) begin
            r = OMAX;
        end else if (r < OMIN) begin
            r = OMIN;
        end
        return OUT_WIDTH'(r);
    endfunction

    // Issue/flow logic; a pop on this edge frees a slot, which keeps the stream gap-free.
    always_comb begin
        valid_c    = (count_q != 2'd0);
        head_c     = mem_q[rd_ptr_q];
        pop_c      = valid_c && bus.ready_i;
        push_c     = pend_q;
        room_c     = (3'(count_q) + 3'(pend_q)) < (3'(2) + 3'(pop_c));
        rd_fire_c  = (state_q == S_RUN) && (issued_q < num_q) && room_c;
        final_rd_c = rd_fire_c && (issued_q == (num_q - CW'(1)));
        wr_entry_c = '{last: pend_last_q, data: requant(bus.bram_data_i, shift_q, relu_q)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        addr_q   <= bus.base_addr_i;
                        num_q    <= bus.num_words_i;
                        shift_q  <= bus.shift_i;
                        relu_q   <= bus.relu_en_i;
                        issued_q <= '0;
                        state_q  <= (bus.num_words_i == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (final_rd_c) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (pop_c && head_c.last) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Address wraps naturally at AW bits.
            if (rd_fire_c) begin
                addr_q   <= addr_q + AW'(1);
                issued_q <= issued_q + CW'(1);
            end

            // BRAM data for a read issued last cycle is valid now.
            pend_q      <= rd_fire_c;
            pend_last_q <= final_rd_c;

            if (push_c) begin
                mem_q[wr_ptr_q] <= wr_entry_c;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_c) - 2'(pop_c);
        end
    end

    assign bus.bram_addr_o = addr_q;
    assign bus.bram_rd_o   = rd_fire_c;
    assign bus.data_o      = head_c.data;
    assign bus.valid_o     = valid_c;
    assign bus.last_o      = valid_c && head_c.last;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = (state_q == S_DONE);

endmodule
